// File: rtl/drum_pad_pkg.sv
// Shared types and sizing helpers for the drum-pad trigger conditioner.
package drum_pad_pkg;

   localparam int unsigned HIT_COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      QUALIFY = 2'd1,
      FIRE    = 2'd2,
      HOLDOFF = 2'd3
   } pad_state_e;

   // Width of the shared per-channel counter: enough to hold max(a, b, c) - 1, at least 1 bit.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/drum_pad_conditioner_if.sv
// Signal bundle between the pad front end / Nios PIO and the conditioner.
interface drum_pad_conditioner_if
   import drum_pad_pkg::*;
#(
   parameter int unsigned NUM_PADS = 4
);

   logic [NUM_PADS-1:0]    pad_raw;
   logic [NUM_PADS-1:0]    pad_en;
   logic                   count_clr;
   logic [NUM_PADS-1:0]    pad_out;
   logic [NUM_PADS-1:0]    hit_strobe;
   logic [HIT_COUNT_W-1:0] hit_count;

   modport master (
      output pad_raw,
      output pad_en,
      output count_clr,
      input  pad_out,
      input  hit_strobe,
      input  hit_count
   );

   modport slave (
      input  pad_raw,
      input  pad_en,
      input  count_clr,
      output pad_out,
      output hit_strobe,
      output hit_count
   );

endinterface

// File: rtl/drum_pad_channel.sv
// One pad channel: 2-flop synchronizer, debounce/stretch/hold-off FSM sharing one counter.
module drum_pad_channel
   import drum_pad_pkg::*;
#(
   parameter bit          ACTIVE_HIGH     = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned STRETCH_CYCLES  = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 2_500_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic pad_raw,
   output logic pad_out,
   output logic hit_strobe
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, STRETCH_CYCLES, HOLDOFF_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

   logic       sync1_q;
   logic       sync2_q;
   logic       active;
   pad_state_e state_q;
   logic [CNT_W-1:0] cnt_q;

   // Two-stage synchronizer; keeps running even while the channel is disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pad_raw;
         sync2_q <= sync1_q;
      end
   end

   assign active = (sync2_q == ACTIVE_HIGH);

   // Strike FSM with registered outputs; disable forces IDLE and truncates any pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pad_out    <= 1'b0;
         hit_strobe <= 1'b0;
      end else if (!en) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pad_out    <= 1'b0;
         hit_strobe <= 1'b0;
      end else begin
         hit_strobe <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (active) begin
                  state_q <= QUALIFY;
                  cnt_q   <= '0;
               end
            end
            QUALIFY: begin
               if (!active) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q    <= FIRE;
                  cnt_q      <= '0;
                  pad_out    <= 1'b1;
                  hit_strobe <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            FIRE: begin
               if (cnt_q == STR_LAST) begin
                  state_q <= HOLDOFF;
                  cnt_q   <= '0;
                  pad_out <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLDOFF: begin
               // Counter saturates at the last value; a held pad must be released to re-arm.
               if (cnt_q != HLD_LAST) begin
                  cnt_q <= cnt_q + 1'b1;
               end else if (!active) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               pad_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/drum_pad_conditioner.sv
// Four-channel drum-pad trigger conditioner with a saturating total-hit counter.
module drum_pad_conditioner
   import drum_pad_pkg::*;
#(
   parameter int unsigned NUM_PADS        = 4,
   parameter bit          ACTIVE_HIGH     = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned STRETCH_CYCLES  = 4,
   parameter int unsigned HOLDOFF_CYCLES  = 2_500_000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   drum_pad_conditioner_if.slave bus
);

   logic [NUM_PADS-1:0]    pad_out;
   logic [NUM_PADS-1:0]    hit_strobe;
   logic [HIT_COUNT_W-1:0] hit_count_q;
   logic [HIT_COUNT_W:0]   hit_sum;

   for (genvar i = 0; i < NUM_PADS; i++) begin : g_chan
      drum_pad_channel #(
         .ACTIVE_HIGH     (ACTIVE_HIGH),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .STRETCH_CYCLES  (STRETCH_CYCLES),
         .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
      ) u_chan (
         .clk        (clk),
         .reset_n    (reset_n),
         .en         (bus.pad_en[i]),
         .pad_raw    (bus.pad_raw[i]),
         .pad_out    (pad_out[i]),
         .hit_strobe (hit_strobe[i])
      );
   end

   // Running total plus this cycle's strobe popcount, one bit wider to detect overflow.
   always_comb begin
      hit_sum = {1'b0, hit_count_q};
      for (int i = 0; i < NUM_PADS; i++) begin
         hit_sum = hit_sum + {{HIT_COUNT_W{1'b0}}, hit_strobe[i]};
      end
   end

   // Saturating hit counter; clear wins and discards strobes of the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_count_q <= '0;
      end else if (bus.count_clr) begin
         hit_count_q <= '0;
      end else if (hit_sum[HIT_COUNT_W]) begin
         hit_count_q <= '1;
      end else begin
         hit_count_q <= hit_sum[HIT_COUNT_W-1:0];
      end
   end

   assign bus.pad_out    = pad_out;
   assign bus.hit_strobe = hit_strobe;
   assign bus.hit_count  = hit_count_q;

endmodule

// File: tb/tb_drum_pad_conditioner.sv
// Directed bench for drum_pad_conditioner with short debounce/stretch/hold-off settings.
module tb_drum_pad_conditioner;

   localparam int unsigned NP = 4;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_fails;
   int   rise_cnt [NP];
   logic [NP-1:0] prev_out;

   drum_pad_conditioner_if #(.NUM_PADS(NP)) bus_if ();

   drum_pad_conditioner #(
      .NUM_PADS        (NP),
      .ACTIVE_HIGH     (1'b1),
      .DEBOUNCE_CYCLES (4),
      .STRETCH_CYCLES  (3),
      .HOLDOFF_CYCLES  (10)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts rising edges seen on each pad_out bit, sampled between active edges.
   always @(negedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (bus_if.pad_out[i] && !prev_out[i]) rise_cnt[i] = rise_cnt[i] + 1;
      end
      prev_out = bus_if.pad_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_count();
      bus_if.count_clr = 1'b1;
      tick();
      bus_if.count_clr = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      prev_out = '0;
      for (int i = 0; i < NP; i++) rise_cnt[i] = 0;
      reset_n          = 1'b0;
      bus_if.pad_raw   = '0;
      bus_if.pad_en    = '1;
      bus_if.count_clr = 1'b0;
      ticks(3);
      chk("rst_pad_out", 32'(bus_if.pad_out), 0);
      chk("rst_strobe", 32'(bus_if.hit_strobe), 0);
      chk("rst_count", 32'(bus_if.hit_count), 0);
      reset_n = 1'b1;
      ticks(2);

      // Clean strike on pad 0, held for 30 cycles
      bus_if.pad_raw[0] = 1'b1;
      ticks(6);
      chk("t1_before_e7", 32'(bus_if.pad_out), 0);
      tick();
      chk("t1_out_e7", 32'(bus_if.pad_out), 4'b0001);
      chk("t1_strobe_e7", 32'(bus_if.hit_strobe), 4'b0001);
      tick();
      chk("t1_out_e8", 32'(bus_if.pad_out), 4'b0001);
      chk("t1_strobe_e8", 32'(bus_if.hit_strobe), 0);
      chk("t1_count_e8", 32'(bus_if.hit_count), 1);
      tick();
      chk("t1_out_e9", 32'(bus_if.pad_out), 4'b0001);
      tick();
      chk("t1_out_e10", 32'(bus_if.pad_out), 0);
      ticks(20);
      bus_if.pad_raw[0] = 1'b0;
      chk("t1_one_pulse", 32'(rise_cnt[0]), 1);
      chk("t1_count_end", 32'(bus_if.hit_count), 1);
      ticks(25);

      // Glitch rejection on pad 1, then an accepted 6-cycle strike
      clear_count();
      chk("t2_clr", 32'(bus_if.hit_count), 0);
      bus_if.pad_raw[1] = 1'b1;
      ticks(3);
      bus_if.pad_raw[1] = 1'b0;
      ticks(15);
      chk("t2_glitch_pulses", 32'(rise_cnt[1]), 0);
      chk("t2_glitch_count", 32'(bus_if.hit_count), 0);
      bus_if.pad_raw[1] = 1'b1;
      ticks(6);
      bus_if.pad_raw[1] = 1'b0;
      tick();
      chk("t2_out_e7", 32'(bus_if.pad_out), 4'b0010);
      ticks(20);
      chk("t2_count", 32'(bus_if.hit_count), 1);
      chk("t2_pulses", 32'(rise_cnt[1]), 1);
      ticks(5);

      // Hold-off on pad 2: re-strike 5 cycles after pad_out falls is ignored
      clear_count();
      bus_if.pad_raw[2] = 1'b1;
      ticks(8);
      bus_if.pad_raw[2] = 1'b0;
      ticks(2);
      chk("t3_fall_e10", 32'(bus_if.pad_out), 0);
      ticks(5);
      bus_if.pad_raw[2] = 1'b1;
      ticks(10);
      bus_if.pad_raw[2] = 1'b0;
      ticks(10);
      chk("t3_ignored_pulses", 32'(rise_cnt[2]), 1);
      chk("t3_ignored_count", 32'(bus_if.hit_count), 1);
      bus_if.pad_raw[2] = 1'b1;
      ticks(7);
      bus_if.pad_raw[2] = 1'b0;
      chk("t3_restrike_out", 32'(bus_if.pad_out), 4'b0100);
      tick();
      chk("t3_count", 32'(bus_if.hit_count), 2);
      ticks(25);

      // All four pads together, then clear in the strobe cycle
      clear_count();
      bus_if.pad_raw = 4'hF;
      ticks(7);
      chk("t4_strobe_all", 32'(bus_if.hit_strobe), 4'hF);
      chk("t4_count_pre", 32'(bus_if.hit_count), 0);
      tick();
      chk("t4_count_plus4", 32'(bus_if.hit_count), 4);
      bus_if.pad_raw = '0;
      ticks(25);
      bus_if.pad_raw = 4'hF;
      ticks(7);
      chk("t4b_strobe_all", 32'(bus_if.hit_strobe), 4'hF);
      bus_if.count_clr = 1'b1;
      tick();
      bus_if.count_clr = 1'b0;
      chk("t4b_clr_wins", 32'(bus_if.hit_count), 0);
      tick();
      chk("t4b_clr_stays", 32'(bus_if.hit_count), 0);
      bus_if.pad_raw = '0;
      ticks(25);

      // Saturation from a preloaded count
      force dut.hit_count_q = 16'hFFFD;
      tick();
      release dut.hit_count_q;
      tick();
      chk("t5_preload", 32'(bus_if.hit_count), 16'hFFFD);
      bus_if.pad_raw = 4'hF;
      ticks(8);
      chk("t5_saturate", 32'(bus_if.hit_count), 16'hFFFF);
      bus_if.pad_raw = '0;
      ticks(25);

      // Disable pad 3 in the middle of its stretch
      bus_if.pad_raw[3] = 1'b1;
      ticks(8);
      chk("t5_fire3", 32'(bus_if.pad_out), 4'b1000);
      bus_if.pad_en[3] = 1'b0;
      tick();
      chk("t5_disable3", 32'(bus_if.pad_out), 0);
      chk("t5_sat_hold", 32'(bus_if.hit_count), 16'hFFFF);
      bus_if.pad_raw[3] = 1'b0;
      bus_if.pad_en     = '1;
      ticks(5);

      // Reset mid-QUALIFY, then mid-FIRE; full latency after each release
      bus_if.pad_raw[0] = 1'b1;
      ticks(4);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6_rstq_out", 32'(bus_if.pad_out), 0);
      chk("t6_rstq_count", 32'(bus_if.hit_count), 0);
      #1;
      reset_n = 1'b1;
      ticks(6);
      chk("t6_lat_e6", 32'(bus_if.pad_out), 0);
      tick();
      chk("t6_lat_e7", 32'(bus_if.pad_out), 4'b0001);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rstf_out", 32'(bus_if.pad_out), 0);
      chk("t6_rstf_strobe", 32'(bus_if.hit_strobe), 0);
      chk("t6_rstf_count", 32'(bus_if.hit_count), 0);
      #1;
      reset_n = 1'b1;
      ticks(6);
      chk("t6_relat_e6", 32'(bus_if.pad_out), 0);
      tick();
      chk("t6_relat_out", 32'(bus_if.pad_out), 4'b0001);
      chk("t6_relat_strobe", 32'(bus_if.hit_strobe), 4'b0001);
      bus_if.pad_raw = '0;
      ticks(25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
